// File: rtl/timer_entry_ctrl.sv
// ---------------------------------------------------------------------------
// timer_entry_ctrl
//
// Purpose:
//   Keypad digit-entry controller for a kitchen-style timer. A key press is
//   debounced for DEBOUNCE_CYCLES cycles, accepted once, and shifted into a
//   four-digit BCD time register (newest digit in the low nibble). A held key
//   yields exactly one digit; the key must be released before the next one.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before a key is accepted (2..255)
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   key_any       in   high while any keypad line is pressed
//   D[3:0]        in   digit code from the keypad priority encoder
//   enablen       out  active-low enable to the priority encoder (registered)
//   entry_en      in   high while entry is permitted (timer not running)
//   clear         in   synchronous clear of the entered time
//   digits[15:0]  out  BCD {min_tens, min_units, sec_tens, sec_units}
//   entry_count   out  number of digits held, 0..4
//   digit_strobe  out  one-cycle pulse when a digit is shifted in
//   digit_err     out  one-cycle pulse when an out-of-range code is rejected
//
// Configuration:
//   DIGIT_RANGE_CHECK_EN  when defined, codes above 9 are rejected in ACCEPT
//                         and digit_err pulses; when undefined, every code is
//                         accepted and digit_err is tied low.
// ---------------------------------------------------------------------------
module timer_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_any,
  input  logic [3:0]  D,
  output logic        enablen,
  input  logic        entry_en,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [2:0]  entry_count,
  output logic        digit_strobe,
  output logic        digit_err
);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_DEBOUNCE     = 2'd1;
  localparam logic [1:0] S_ACCEPT       = 2'd2;
  localparam logic [1:0] S_WAIT_RELEASE = 2'd3;

  // Counter value on the last DEBOUNCE cycle; DEBOUNCE spans counts 0..CNT_LAST.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [2:0]  count_q, count_d;
  logic        strobe_q, strobe_d;
  logic        enablen_q, enablen_d;
`ifdef DIGIT_RANGE_CHECK_EN
  logic        err_q, err_d;
`endif

  // Next-state, datapath and pulse computation.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    count_d  = count_q;
    strobe_d = 1'b0;
`ifdef DIGIT_RANGE_CHECK_EN
    err_d    = 1'b0;
`endif

    if (clear) begin
      // Clear wipes the time and parks in WAIT_RELEASE so a held key is
      // not taken until it is released and pressed again.
      digits_d = 16'h0000;
      count_d  = 3'd0;
      state_d  = S_WAIT_RELEASE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (entry_en && key_any) begin
            cand_d  = D;
            cnt_d   = 8'd0;
            state_d = S_DEBOUNCE;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_DEBOUNCE: begin
          if (!key_any || (D != cand_q) || !entry_en) begin
            state_d = S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_ACCEPT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        S_ACCEPT: begin
          state_d = S_WAIT_RELEASE;
          if (entry_en && (count_q < 3'd4)) begin
`ifdef DIGIT_RANGE_CHECK_EN
            if (cand_q > 4'd9) begin
              err_d = 1'b1;
            end else begin
              digits_d = {digits_q[11:0], cand_q};
              count_d  = count_q + 3'd1;
              strobe_d = 1'b1;
            end
`else
            digits_d = {digits_q[11:0], cand_q};
            count_d  = count_q + 3'd1;
            strobe_d = 1'b1;
`endif
          end else begin
            // Full register or entry disabled: key is silently discarded.
            digits_d = digits_q;
          end
        end

        S_WAIT_RELEASE: begin
          if (key_any) begin
            state_d = S_WAIT_RELEASE;
          end else begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Encoder is enabled whenever entry is allowed and we are not waiting for release.
    enablen_d = ~(entry_en & (state_d != S_WAIT_RELEASE));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cand_q    <= 4'd0;
      cnt_q     <= 8'd0;
      digits_q  <= 16'h0000;
      count_q   <= 3'd0;
      strobe_q  <= 1'b0;
      enablen_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      count_q   <= count_d;
      strobe_q  <= strobe_d;
      enablen_q <= enablen_d;
    end
  end

`ifdef DIGIT_RANGE_CHECK_EN
  // Rejected-code pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign digit_err = err_q;
`else
  assign digit_err = 1'b0;
`endif

  assign enablen      = enablen_q;
  assign digits       = digits_q;
  assign entry_count  = count_q;
  assign digit_strobe = strobe_q;

endmodule

// File: doc/timer_entry_ctrl.md
TIMER_ENTRY_CTRL -- requirements
Module: timer_entry_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4 (range 2..255): consecutive stable cycles needed before a key is accepted.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port key_any  input  1  high while any keypad line is pressed (OR of the 10 keypad lines).
REQ-005 SHALL have port D  input  4  digit code from the keypad priority encoder.
REQ-006 SHALL have port enablen  output  1  active-low enable driven to the priority encoder.
REQ-007 SHALL have port entry_en  input  1  high while timer entry is permitted (timer not running).
REQ-008 SHALL have port clear  input  1  synchronous clear of the entered time.
REQ-009 SHALL have port digits  output  16  BCD time {min_tens, min_units, sec_tens, sec_units}; newest digit in [3:0].
REQ-010 SHALL have port entry_count  output  3  number of digits held, 0..4.
REQ-011 SHALL have port digit_strobe  output  1  one-cycle pulse when a digit is shifted in.
REQ-012 SHALL have port digit_err  output  1  one-cycle pulse when an out-of-range code is rejected.

Function
REQ-013 SHALL implement states IDLE, DEBOUNCE, ACCEPT and WAIT_RELEASE.
REQ-014 enablen SHALL be 0 when entry_en=1 and state is IDLE, DEBOUNCE or ACCEPT; otherwise 1.
REQ-015 IDLE: if entry_en=1 and key_any=1, latch D into cand, clear counter, go to DEBOUNCE; otherwise stay in IDLE.
REQ-016 DEBOUNCE: if key_any=0, D!=cand or entry_en=0, go to IDLE with no digit taken; otherwise increment counter.
REQ-017 DEBOUNCE: the cycle counter reaches DEBOUNCE_CYCLES-1 with inputs still stable, go to ACCEPT; DEBOUNCE therefore lasts exactly DEBOUNCE_CYCLES cycles.
REQ-018 ACCEPT (one cycle): if entry_en=1, entry_count<4 and cand is accepted, set digits <= {digits[11:0], cand}, increment entry_count and pulse digit_strobe; always go to WAIT_RELEASE.
REQ-019 ACCEPT with entry_count=4 SHALL discard the key: digits unchanged, no strobe, no digit_err.
REQ-020 ACCEPT with entry_en=0 SHALL discard the key and go to WAIT_RELEASE.
REQ-021 WAIT_RELEASE: stay while key_any=1; go to IDLE on the first cycle key_any=0. A held key SHALL produce exactly one digit.
REQ-022 clear=1 SHALL set digits=0, entry_count=0, suppress strobe and error pulses, and go to WAIT_RELEASE; rst has priority over clear.
REQ-023 digit_strobe and digit_err SHALL be registered outputs, asserted in the cycle after ACCEPT, and never asserted together.
REQ-024 Latency from the first cycle key_any=1 in IDLE to digit_strobe high SHALL be DEBOUNCE_CYCLES+2 cycles.

Reset
REQ-025 rst=1 SHALL set state=IDLE, digits=16'h0000, entry_count=0, digit_strobe=0, digit_err=0, enablen=1 on the next clock edge.
REQ-026 rst asserted mid-entry (any state) SHALL discard the candidate key; no strobe SHALL follow the release of rst.
REQ-027 After rst deasserts with a key still held, the block SHALL treat it as a new press from IDLE.

Configuration
REQ-028 Macro DIGIT_RANGE_CHECK_EN defined: in ACCEPT, cand>9 SHALL be rejected (digits and entry_count unchanged, digit_err pulsed, go to WAIT_RELEASE).
REQ-029 Macro DIGIT_RANGE_CHECK_EN undefined: every cand SHALL be accepted; digit_err SHALL be tied to 0.

Verification
REQ-030 Reset then entry_en=1; press 1, 2, 3, 0, each held 10 cycles with release gaps -> digits=16'h1230, entry_count=4, four strobes.
REQ-031 Fifth press of 7 after four digits -> digits stays 16'h1230, no strobe.
REQ-032 DEBOUNCE_CYCLES=4; key_any glitches high for 3 cycles with D=5 -> no strobe, state returns to IDLE; held 20 cycles -> exactly one strobe, 6 cycles after press.
REQ-033 D changes from 4 to 8 mid-DEBOUNCE -> debounce restarts from IDLE; digit 8 accepted only after a further 4 stable cycles.
REQ-034 clear pulsed while key 9 is held after entering 16'h0045 -> digits=0, entry_count=0, no strobe until release and re-press.
REQ-035 With DIGIT_RANGE_CHECK_EN, D=4'hC held -> digit_err pulse, digits unchanged; without it -> strobe, digits[3:0]=4'hC.
